// File: rtl/cmp_sweep_sequencer.sv
// Phase-sweep acquisition sequencer: steps the MMCM shifting-clock phase, counts comparator
// ones over a fixed window per step and streams two packed 32-bit words per step.
module cmp_sweep_sequencer #(
    parameter int STEPS        = 448,
    parameter int SAMPLES_LOG2 = 10,
    parameter int SETTLE       = 16,
    parameter int PS_TIMEOUT   = 255
) (
    input  logic        shifting_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        cmp_ref,
    input  logic        cmp_s11,
    input  logic        cmp_s21,
    output logic        ps_en,
    output logic        ps_incdec,
    input  logic        ps_done,
    output logic [31:0] gth_data,
    output logic        gth_valid,
    input  logic        gth_ready,
    output logic        triger,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] step_idx,
    output logic [2:0]  dbg_state
);

    // gth_data/gth_valid form a valid/ready source: once gth_valid rises, the word and valid
    // hold until a cycle with gth_valid & gth_ready; only abort or reset drop valid earlier.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_WAIT_PS = 3'd2,
        S_SETTLE  = 3'd3,
        S_ACQ     = 3'd4,
        S_EMIT0   = 3'd5,
        S_EMIT1   = 3'd6
    } state_t;

    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(PS_TIMEOUT + 1);
    localparam logic [SW-1:0]           SETTLE_LAST  = SW'(SETTLE - 1);
    localparam logic [TW-1:0]           TIMEOUT_LAST = TW'(PS_TIMEOUT - 1);
    localparam logic [11:0]             LAST_STEP    = 12'(STEPS - 1);
    localparam logic [SAMPLES_LOG2-1:0] SAMPLE_LAST  = '1;

    state_t                  state;
    logic [SW-1:0]           settle_cnt;
    logic [TW-1:0]           wait_cnt;
    logic [SAMPLES_LOG2-1:0] sample_cnt;
    logic [15:0]             cnt_ref;
    logic [15:0]             cnt_s11;
    logic [15:0]             cnt_s21;
    logic                    handshake;

    assign handshake = gth_valid & gth_ready;
    assign busy      = (state != S_IDLE);
    assign ps_incdec = 1'b1;
    assign dbg_state = state;

    always_ff @(posedge shifting_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            wait_cnt   <= '0;
            sample_cnt <= '0;
            cnt_ref    <= '0;
            cnt_s11    <= '0;
            cnt_s21    <= '0;
            ps_en      <= 1'b0;
            gth_data   <= '0;
            gth_valid  <= 1'b0;
            triger     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            step_idx   <= '0;
        end else begin
            ps_en  <= 1'b0;
            triger <= 1'b0;
            done   <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                gth_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Step 0 samples at the current phase, so no shift is issued first.
                        if (start) begin
                            state      <= S_SETTLE;
                            step_idx   <= '0;
                            err        <= 1'b0;
                            settle_cnt <= '0;
                        end
                    end
                    S_SHIFT: begin
                        state    <= S_WAIT_PS;
                        wait_cnt <= TW'(1);
                    end
                    S_WAIT_PS: begin
                        // wait_cnt is the number of cycles since the ps_en pulse.
                        if (ps_done) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                        end else if (wait_cnt >= TIMEOUT_LAST) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= S_ACQ;
                            sample_cnt <= '0;
                            cnt_ref    <= '0;
                            cnt_s11    <= '0;
                            cnt_s21    <= '0;
                            triger     <= (step_idx == 12'd0);
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                    S_ACQ: begin
                        cnt_ref    <= cnt_ref + 16'(cmp_ref);
                        cnt_s11    <= cnt_s11 + 16'(cmp_s11);
                        cnt_s21    <= cnt_s21 + 16'(cmp_s21);
                        sample_cnt <= sample_cnt + SAMPLES_LOG2'(1);
                        // The last sample is folded straight into the first word.
                        if (sample_cnt == SAMPLE_LAST) begin
                            state     <= S_EMIT0;
                            gth_valid <= 1'b1;
                            gth_data  <= {4'hA, step_idx, cnt_ref + 16'(cmp_ref)};
                        end
                    end
                    S_EMIT0: begin
                        if (handshake) begin
                            state    <= S_EMIT1;
                            gth_data <= {cnt_s11, cnt_s21};
                        end
                    end
                    S_EMIT1: begin
                        if (handshake) begin
                            gth_valid <= 1'b0;
                            if (step_idx == LAST_STEP) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                step_idx <= step_idx + 12'd1;
                                ps_en    <= 1'b1;
                                state    <= S_SHIFT;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmp_sweep_sequencer.sv
// Directed bench for cmp_sweep_sequencer: full sweep, backpressure, phase-shift timeout,
// abort, overlapping control and counter maximum, with a word scoreboard.
module tb_cmp_sweep_sequencer;

    localparam int STEPS = 4, SLOG = 4, SETTLE = 2, PS_TO = 8;
    localparam logic [31:0] ST_IDLE = 0, ST_WAIT_PS = 2, ST_SETTLE = 3, ST_ACQ = 4,
                            ST_EMIT0 = 5, ST_EMIT1 = 6;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, abort = 1'b0, ps_done = 1'b0, gth_ready = 1'b0;
    logic cmp_ref = 1'b1, cmp_s11 = 1'b0, cmp_s21 = 1'b0;
    logic        ps_en, ps_incdec, gth_valid, triger, busy, done, err;
    logic [31:0] gth_data;
    logic [11:0] step_idx;
    logic [2:0]  dbg_state;

    logic        m_start = 1'b0;
    logic        m_ps_en, m_ps_incdec, m_gth_valid, m_triger, m_busy, m_done, m_err;
    logic [31:0] m_gth_data;
    logic [11:0] m_step_idx;
    logic [2:0]  m_dbg_state;

    always #5 clk = ~clk;

    cmp_sweep_sequencer #(.STEPS(STEPS), .SAMPLES_LOG2(SLOG), .SETTLE(SETTLE), .PS_TIMEOUT(PS_TO)) dut (
        .shifting_clk(clk), .reset(reset), .start(start), .abort(abort),
        .cmp_ref(cmp_ref), .cmp_s11(cmp_s11), .cmp_s21(cmp_s21),
        .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done),
        .gth_data(gth_data), .gth_valid(gth_valid), .gth_ready(gth_ready),
        .triger(triger), .busy(busy), .done(done), .err(err),
        .step_idx(step_idx), .dbg_state(dbg_state)
    );

    cmp_sweep_sequencer #(.STEPS(1), .SAMPLES_LOG2(15), .SETTLE(1), .PS_TIMEOUT(8)) dut_max (
        .shifting_clk(clk), .reset(reset), .start(m_start), .abort(1'b0),
        .cmp_ref(1'b1), .cmp_s11(1'b1), .cmp_s21(1'b1),
        .ps_en(m_ps_en), .ps_incdec(m_ps_incdec), .ps_done(1'b0),
        .gth_data(m_gth_data), .gth_valid(m_gth_valid), .gth_ready(1'b1),
        .triger(m_triger), .busy(m_busy), .done(m_done), .err(m_err),
        .step_idx(m_step_idx), .dbg_state(m_dbg_state)
    );

    // ---------------- scoreboard state and checker ----------------
    logic [31:0] exp_q[$];
    int n_pass = 0, n_checks = 0, n_fail = 0;
    int ps_en_cnt = 0, triger_cnt = 0, done_cnt = 0, word_cnt = 0;
    logic ps_resp_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sweep(input int n_steps);
        for (int s = 0; s < n_steps; s++) begin
            exp_q.push_back({4'hA, 12'(s), 16'h0010});
            exp_q.push_back(32'h0000_0008);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int elapsed);
        elapsed = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done) begin
                elapsed = i;
                break;
            end
        end
    endtask

    // cmp_s21 toggles every cycle, so any 16-cycle window holds exactly 8 ones.
    initial forever begin
        @(negedge clk);
        cmp_s21 = ~cmp_s21;
    end

    // MMCM model: ps_done arrives 3 cycles after ps_en when enabled.
    initial begin
        int ps_dly;
        ps_dly = 0;
        forever begin
            @(negedge clk);
            ps_done = 1'b0;
            if (ps_dly > 0) begin
                ps_dly--;
                if (ps_dly == 0) ps_done = 1'b1;
            end
            if (ps_en && ps_resp_en) ps_dly = 3;
        end
    end

    // Output monitor: pops the scoreboard on every handshake and checks held words.
    initial begin
        logic        hold_pending;
        logic [31:0] hold_data;
        hold_pending = 1'b0;
        hold_data    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_pending = 1'b0;
            end else begin
                if (ps_en)  ps_en_cnt++;
                if (triger) triger_cnt++;
                if (done)   done_cnt++;
                if (hold_pending) begin
                    chk("hold_valid", 32'(gth_valid), 32'd1);
                    chk("hold_data", gth_data, hold_data);
                end
                if (gth_valid && gth_ready) begin
                    word_cnt++;
                    if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                    else chk("sb_word", gth_data, exp_q.pop_front());
                end
                hold_pending = gth_valid && !gth_ready && !abort;
                hold_data    = gth_data;
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ps_en"}, 32'(ps_en), 32'd0);
        chk({tag, "_ps_incdec"}, 32'(ps_incdec), 32'd1);
        chk({tag, "_valid"}, 32'(gth_valid), 32'd0);
        chk({tag, "_data"}, gth_data, 32'd0);
        chk({tag, "_triger"}, 32'(triger), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_step_idx"}, 32'(step_idx), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), ST_IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int p0, t0, d0, w0, el, mps, mtr;

        tick(3);
        chk_reset_values("rst");
        chk("rst_m_busy", 32'(m_busy), 32'd0);
        reset = 1'b0;
        gth_ready = 1'b1;
        ps_resp_en = 1'b1;
        tick();

        // Full sweep with timing checks.
        p0 = ps_en_cnt; t0 = triger_cnt; d0 = done_cnt; w0 = word_cnt;
        push_sweep(4);
        pulse_start();
        chk("fs_busy", 32'(busy), 32'd1);
        chk("fs_state_settle", 32'(dbg_state), ST_SETTLE);
        tick();
        chk("fs_triger_early", 32'(triger), 32'd0);
        tick();
        chk("fs_triger", 32'(triger), 32'd1);
        chk("fs_state_acq", 32'(dbg_state), ST_ACQ);
        tick(16);
        chk("fs_valid_rise", 32'(gth_valid), 32'd1);
        chk("fs_word0", gth_data, 32'hA000_0010);
        wait_done(200, el);
        chk("fs_done", 32'(done), 32'd1);
        chk("fs_latency", 32'(el), 32'd74);
        chk("fs_busy_at_done", 32'(busy), 32'd0);
        tick(2);
        chk("fs_ps_en_count", 32'(ps_en_cnt - p0), 32'd3);
        chk("fs_triger_count", 32'(triger_cnt - t0), 32'd1);
        chk("fs_done_count", 32'(done_cnt - d0), 32'd1);
        chk("fs_word_count", 32'(word_cnt - w0), 32'd8);
        chk("fs_err", 32'(err), 32'd0);
        chk("fs_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure in EMIT0 and EMIT1.
        p0 = ps_en_cnt; w0 = word_cnt;
        gth_ready = 1'b0;
        push_sweep(4);
        pulse_start();
        for (int i = 0; i < 50 && !gth_valid; i++) tick();
        chk("bp_valid", 32'(gth_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_word0_held", gth_data, 32'hA000_0010);
            chk("bp_state_emit0", 32'(dbg_state), ST_EMIT0);
            chk("bp_no_ps_en", 32'(ps_en), 32'd0);
            tick();
        end
        gth_ready = 1'b1;
        tick();
        gth_ready = 1'b0;
        chk("bp_state_emit1", 32'(dbg_state), ST_EMIT1);
        chk("bp_word1", gth_data, 32'h0000_0008);
        tick(2);
        chk("bp_no_ps_en_emit1", 32'(ps_en), 32'd0);
        chk("bp_still_emit1", 32'(dbg_state), ST_EMIT1);
        gth_ready = 1'b1;
        wait_done(200, el);
        chk("bp_done", 32'(done), 32'd1);
        tick(2);
        chk("bp_ps_en_count", 32'(ps_en_cnt - p0), 32'd3);
        chk("bp_word_count", 32'(word_cnt - w0), 32'd8);
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Phase-shift timeout.
        ps_resp_en = 1'b0;
        d0 = done_cnt;
        push_sweep(1);
        pulse_start();
        for (int i = 0; i < 60 && !ps_en; i++) tick();
        chk("to_shift", 32'(ps_en), 32'd1);
        chk("to_step_idx", 32'(step_idx), 32'd1);
        for (int j = 1; j < PS_TO; j++) begin
            tick();
            chk("to_err_early", 32'(err), 32'd0);
            chk("to_busy_wait", 32'(busy), 32'd1);
        end
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_state", 32'(dbg_state), ST_IDLE);
        tick(3);
        chk("to_no_done", 32'(done_cnt - d0), 32'd0);
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_sb_empty", 32'(exp_q.size()), 32'd0);

        // Abort mid-ACQ of step 2, then abort+start collision, then a fresh sweep.
        ps_resp_en = 1'b1;
        push_sweep(2);
        pulse_start();
        chk("ab_start_clears_err", 32'(err), 32'd0);
        chk("ab_step_idx0", 32'(step_idx), 32'd0);
        for (int i = 0; i < 200 && !(step_idx == 12'd2 && dbg_state == 3'(ST_ACQ)); i++) tick();
        chk("ab_in_acq", 32'(dbg_state), ST_ACQ);
        tick(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_valid", 32'(gth_valid), 32'd0);
        chk("ab_state", 32'(dbg_state), ST_IDLE);
        chk("ab_err_kept", 32'(err), 32'd0);
        chk("ab_sb_empty", 32'(exp_q.size()), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("ab_start_collision", 32'(dbg_state), ST_IDLE);
        p0 = ps_en_cnt; w0 = word_cnt;
        push_sweep(4);
        pulse_start();
        chk("ab_restart_step0", 32'(step_idx), 32'd0);
        wait_done(200, el);
        chk("ab_restart_done", 32'(done), 32'd1);
        tick();
        chk("ab_restart_words", 32'(word_cnt - w0), 32'd8);
        chk("ab_restart_ps_en", 32'(ps_en_cnt - p0), 32'd3);

        // Ignored start while busy, then reset during EMIT1 with backpressure.
        push_sweep(4);
        pulse_start();
        tick(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ov_start_ignored", 32'(dbg_state), ST_ACQ);
        chk("ov_step_idx", 32'(step_idx), 32'd0);
        for (int i = 0; i < 200 && !(step_idx == 12'd1 && dbg_state == 3'(ST_EMIT0)); i++) tick();
        chk("ov_in_emit0", 32'(dbg_state), ST_EMIT0);
        tick();
        gth_ready = 1'b0;
        chk("ov_in_emit1", 32'(dbg_state), ST_EMIT1);
        tick(2);
        chk("ov_emit1_valid", 32'(gth_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk_reset_values("ov_rst");
        chk("ov_sb_left", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        reset = 1'b0;
        gth_ready = 1'b1;
        tick();

        // Counter maximum and STEPS=1 on the second instance.
        mps = 0; mtr = 0;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        for (int i = 0; i < 33000 && !m_gth_valid; i++) begin
            tick();
            if (m_ps_en)  mps++;
            if (m_triger) mtr++;
        end
        chk("mx_valid", 32'(m_gth_valid), 32'd1);
        chk("mx_word0", m_gth_data, 32'hA000_8000);
        tick();
        chk("mx_word1", m_gth_data, 32'h8000_8000);
        chk("mx_valid1", 32'(m_gth_valid), 32'd1);
        tick();
        chk("mx_done", 32'(m_done), 32'd1);
        chk("mx_busy", 32'(m_busy), 32'd0);
        chk("mx_no_shift", 32'(mps), 32'd0);
        chk("mx_triger_count", 32'(mtr), 32'd1);
        chk("mx_err", 32'(m_err), 32'd0);

        // ---------------- final report ----------------
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmp_sweep_sequencer.md
# cmp_sweep_sequencer

Phase-sweep acquisition sequencer for the anti-probe comparator front end. It steps the shifting-clock phase through the MMCM dynamic phase-shift port and, at each step, counts ones on the registered ref, S11 and S21 comparator bits over a fixed window. It packs the counts into 32-bit words for the GTH transmit datapath under a valid/ready handshake. It sits between the comparator capture registers and the `gth_data` input of the transceiver wrapper, and it drives `triger` for the external scope.

## Interface
- `STEPS`, 448: phase steps per sweep, 1..4096.
- `SAMPLES_LOG2`, 10: the sample window is 2^SAMPLES_LOG2 cycles, 1..15.
- `SETTLE`, 16: wait cycles after each phase change before sampling, ≥1.
- `PS_TIMEOUT`, 255: maximum cycles to wait for `ps_done`, ≥1.

Ports:
- `shifting_clk` in 1: the only clock. The phase-shift port runs in this domain (psclk = shifting_clk).
- `reset` in 1: synchronous, active-high.
- `start` in 1: starts a sweep. It is honoured only in IDLE.
- `abort` in 1: stops the sweep. It takes effect synchronously from any state.
- `cmp_ref`, `cmp_s11`, `cmp_s21` in 1 each: comparator bits, already registered on `shifting_clk`.
- `ps_en` out 1: phase-shift request, a one-cycle pulse.
- `ps_incdec` out 1: phase-shift direction. It is tied to 1 (increment).
- `ps_done` in 1: phase-shift complete, a one-cycle pulse from the MMCM.
- `gth_data` out 32: packed output word.
- `gth_valid` out 1: the word on `gth_data` is valid.
- `gth_ready` in 1: the word is accepted on any cycle with `gth_valid & gth_ready`.
- `triger` out 1: one-cycle pulse on the first sample cycle of step 0.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when a sweep completes normally.
- `err` out 1: sticky phase-shift timeout flag.
- `step_idx` out 12: current step number.

## Operation
States:
- **IDLE**: waits for `start`.
- **SHIFT**: asserts `ps_en` for one cycle.
- **WAIT_PS**: waits for `ps_done`, with a timeout.
- **SETTLE**: waits SETTLE cycles.
- **ACQ**: counts samples.
- **EMIT0**: presents the first output word.
- **EMIT1**: presents the second output word.

Transitions:
- IDLE + `start`: go to SETTLE. Clear `step_idx` and `err`. Step 0 uses the current phase, so no shift is issued.
- SHIFT → WAIT_PS unconditionally. `ps_en`=1 only during SHIFT.
- WAIT_PS:
  - `ps_done` → SETTLE.
  - After PS_TIMEOUT cycles without `ps_done`, set `err`=1 and go to IDLE. `done` is not pulsed.
- SETTLE: stays exactly SETTLE cycles, then goes to ACQ.
- ACQ:
  - On entry, all three counters restart.
  - Each of the 2^SAMPLES_LOG2 cycles adds the current `cmp_*` bit to its 16-bit counter.
  - After the last sample cycle, go to EMIT0.
- EMIT0:
  - `gth_data` = {4'hA, `step_idx`[11:0], cnt_ref[15:0]}.
  - Go to EMIT1 on handshake.
- EMIT1:
  - `gth_data` = {cnt_s11[15:0], cnt_s21[15:0]}.
  - On handshake, if `step_idx`==STEPS-1: pulse `done` and go to IDLE.
  - Otherwise increment `step_idx` and go to SHIFT.
- `abort` (any state): go to IDLE next cycle. Drop `gth_valid`. Leave `err` unchanged. Do not pulse `done`.
- `start` outside IDLE is ignored.

Arithmetic and word rules:
- A counter's maximum is 2^15 = 0x8000, so no counter overflows.
- `step_idx` is zero-extended to 12 bits.
- A full sweep issues exactly STEPS-1 `ps_en` pulses and emits exactly 2·STEPS words.

## Timing
Reset values: state IDLE. All outputs are 0 except `ps_incdec`=1.

Per-step timing:
- `start` at cycle t: `busy`=1 at t+1, and SETTLE spans t+1..t+SETTLE.
- ACQ spans t+SETTLE+1..t+SETTLE+2^SAMPLES_LOG2. `triger`=1 on the first ACQ cycle of step 0 only.
- `gth_valid` rises the cycle after the last ACQ cycle.
- Step-to-step latency with `gth_ready`=1 and `ps_done` arriving d cycles after `ps_en` is 2 + 1 + d + SETTLE + 2^SAMPLES_LOG2 cycles (EMIT0, EMIT1, SHIFT, WAIT_PS, SETTLE, ACQ).

Handshake and pulse rules:
- `gth_data` is registered.
- `gth_valid` and `gth_data` hold stable while `gth_ready`=0. Only `abort` or `reset` may drop valid before acceptance.
- A `ps_done` arriving in any state other than WAIT_PS is ignored.
- `done` is high in the cycle after the final EMIT1 handshake, coincident with `busy`=0.

Boundary cases:
- STEPS=1: no SHIFT is ever issued.
- Simultaneous `abort` and `start` in IDLE: `abort` wins and the state stays IDLE.
- Simultaneous `abort` and handshake: the word counts as transferred, and the state still goes to IDLE.
- `reset` mid-operation: all outputs return to their reset values on the next edge.

## Test plan
- **Full sweep.** STEPS=4, SAMPLES_LOG2=4, SETTLE=2. `cmp_ref`=1, `cmp_s11`=0, `cmp_s21` toggling; `gth_ready`=1; `ps_done` 3 cycles after `ps_en`. Required: 8 words; step 0 words are 0xA0000010 and 0x00000008; step 3 word0 is 0xA0030010; 3 `ps_en` pulses; 1 `triger`; 1 `done`; `err`=0.
- **Backpressure.** Hold `gth_ready`=0 for 10 cycles in EMIT0. Required: `gth_data` and `gth_valid` stable throughout; no `ps_en` until both words are accepted; word order unchanged.
- **Phase-shift timeout.** PS_TIMEOUT=8, `ps_done` never asserted. Required: `err`=1 exactly 8 cycles after SHIFT; `busy`=0; no `done`. The next `start` clears `err`.
- **Abort.** Assert `abort` mid-ACQ of step 2, then `start` again. Required: `busy`=0 and `gth_valid`=0 the next cycle; the new sweep begins at `step_idx`=0 with fresh counts.
- **Overlapping control.** Pulse `start` while `busy`, then assert `reset` during EMIT1 with `gth_ready`=0. Required: the `start` is ignored; after reset all outputs are 0, `ps_incdec`=1, state IDLE.
- **Counter maximum.** SAMPLES_LOG2=15 with all `cmp_*`=1. Required: word0 low half 0x8000; word1 = 0x80008000.
